mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// N-channel memory arbiter: one-deep request buffer per channel, serialised onto a single valid/ready bus.
// Define ARBITER_ROUND_ROBIN_EN for round-robin selection; otherwise lowest eligible index wins.
module mem_arbiter #(
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 rst,
  input  logic                                 clk,
  input  logic [CHANNELS-1:0]                  req_valid,
  input  logic [CHANNELS-1:0]                  req_instr,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]       req_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       req_wdata,
  input  logic [CHANNELS*(DATA_WIDTH/8)-1:0]   req_wstrb,
  output logic [CHANNELS-1:0]                  resp_ready,
  output logic [DATA_WIDTH-1:0]                resp_rdata,
  output logic                                 memory_valid,
  output logic                                 memory_instr,
  output logic [ADDR_WIDTH-1:0]                memory_addr,
  output logic [DATA_WIDTH-1:0]                memory_wdata,
  output logic [DATA_WIDTH/8-1:0]              memory_wstrb,
  input  logic [DATA_WIDTH-1:0]                memory_rdata,
  input  logic                                 memory_ready
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state;
  logic [GW-1:0]         gnt;
  logic [CHANNELS-1:0]   pend;
  logic [CHANNELS-1:0]   pend_instr;
  logic [ADDR_WIDTH-1:0] pend_addr  [CHANNELS];
  logic [DATA_WIDTH-1:0] pend_wdata [CHANNELS];
  logic [SW-1:0]         pend_wstrb [CHANNELS];

  logic [CHANNELS-1:0]   elig;
  logic [CHANNELS-1:0]   win_oh;
  logic                  found;
  logic [GW-1:0]         win_idx;
  logic                  win_instr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [SW-1:0]         win_wstrb;
  logic                  take;
  logic                  grant;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic [GW-1:0]         last;
  int                    idx;
`endif

  assign memory_valid = (state == BUSY);

  always_comb begin
    // Incoming pulses bypass the buffer; the channel currently on the bus is never eligible.
    elig = pend | req_valid;
    for (int i = 0; i < CHANNELS; i++) begin
      if (state == BUSY && gnt == GW'(i)) elig[i] = 1'b0;
    end

    found  = 1'b0;
    win_oh = '0;
`ifdef ARBITER_ROUND_ROBIN_EN
    idx = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(last) + 1 + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && elig[i] && idx == i) begin
          win_oh[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
`else
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && elig[i]) begin
        win_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
`endif

    win_idx   = '0;
    win_instr = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_wstrb = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (win_oh[i]) begin
        win_idx   = GW'(i);
        win_instr = pend[i] ? pend_instr[i] : req_instr[i];
        win_addr  = pend[i] ? pend_addr[i]  : req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = pend[i] ? pend_wdata[i] : req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        win_wstrb = pend[i] ? pend_wstrb[i] : req_wstrb[i*SW +: SW];
      end
    end

    take  = (state == IDLE) || memory_ready;
    grant = take && found;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      gnt          <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last         <= GW'(CHANNELS - 1);
`endif
      pend         <= '0;
      pend_instr   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_addr[i]  <= '0;
        pend_wdata[i] <= '0;
        pend_wstrb[i] <= '0;
      end
      memory_instr <= 1'b0;
      memory_addr  <= '0;
      memory_wdata <= '0;
      memory_wstrb <= '0;
      resp_ready   <= '0;
      resp_rdata   <= '0;
    end else begin
      resp_ready <= '0;
      if (state == BUSY && memory_ready) begin
        resp_rdata <= memory_rdata;
        for (int i = 0; i < CHANNELS; i++) begin
          if (gnt == GW'(i)) resp_ready[i] <= 1'b1;
        end
      end

      // A completing handshake may load the next winner in the same cycle (no bubble).
      if (grant) begin
        state        <= BUSY;
        gnt          <= win_idx;
`ifdef ARBITER_ROUND_ROBIN_EN
        last         <= win_idx;
`endif
        memory_instr <= win_instr;
        memory_addr  <= win_addr;
        memory_wdata <= win_wdata;
        memory_wstrb <= win_wstrb;
      end else if (state == BUSY && memory_ready) begin
        state <= IDLE;
      end

      for (int i = 0; i < CHANNELS; i++) begin
        if (req_valid[i]) begin
          pend[i]       <= 1'b1;
          pend_instr[i] <= req_instr[i];
          pend_addr[i]  <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          pend_wdata[i] <= req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          pend_wstrb[i] <= req_wstrb[i*SW +: SW];
        end
        if (grant && win_oh[i]) pend[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (2, 3 and 1 channels) driven in one linear sequence.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance a: 2 channels
  logic        a_rst;
  logic [1:0]  a_req_valid, a_req_instr, a_resp_ready;
  logic [63:0] a_req_addr, a_req_wdata;
  logic [7:0]  a_req_wstrb;
  logic [31:0] a_resp_rdata, a_ma, a_mw, a_mrdata;
  logic        a_mv, a_mi, a_mready;
  logic [3:0]  a_ms;

  // Instance b: 3 channels
  logic        b_rst;
  logic [2:0]  b_req_valid, b_req_instr, b_resp_ready;
  logic [95:0] b_req_addr, b_req_wdata;
  logic [11:0] b_req_wstrb;
  logic [31:0] b_resp_rdata, b_ma, b_mw, b_mrdata;
  logic        b_mv, b_mi, b_mready;
  logic [3:0]  b_ms;

  // Instance c: 1 channel
  logic        c_rst;
  logic [0:0]  c_req_valid, c_req_instr, c_resp_ready;
  logic [31:0] c_req_addr, c_req_wdata;
  logic [3:0]  c_req_wstrb;
  logic [31:0] c_resp_rdata, c_ma, c_mw, c_mrdata;
  logic        c_mv, c_mi, c_mready;
  logic [3:0]  c_ms;

  mem_arbiter #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_a (
    .rst(a_rst), .clk(clk), .req_valid(a_req_valid), .req_instr(a_req_instr),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata), .memory_valid(a_mv),
    .memory_instr(a_mi), .memory_addr(a_ma), .memory_wdata(a_mw), .memory_wstrb(a_ms),
    .memory_rdata(a_mrdata), .memory_ready(a_mready));

  mem_arbiter #(.CHANNELS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_b (
    .rst(b_rst), .clk(clk), .req_valid(b_req_valid), .req_instr(b_req_instr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .memory_valid(b_mv),
    .memory_instr(b_mi), .memory_addr(b_ma), .memory_wdata(b_mw), .memory_wstrb(b_ms),
    .memory_rdata(b_mrdata), .memory_ready(b_mready));

  mem_arbiter #(.CHANNELS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_c (
    .rst(c_rst), .clk(clk), .req_valid(c_req_valid), .req_instr(c_req_instr),
    .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_wstrb(c_req_wstrb),
    .resp_ready(c_resp_ready), .resp_rdata(c_resp_rdata), .memory_valid(c_mv),
    .memory_instr(c_mi), .memory_addr(c_ma), .memory_wdata(c_mw), .memory_wstrb(c_ms),
    .memory_rdata(c_mrdata), .memory_ready(c_mready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] b_exp_addr [4];
  logic [2:0]  b_exp_resp [5];

  initial begin
    a_rst = 1'b0; a_req_valid = '0; a_req_instr = '0; a_req_addr = '0; a_req_wdata = '0;
    a_req_wstrb = '0; a_mrdata = '0; a_mready = 1'b0;
    b_rst = 1'b0; b_req_valid = '0; b_req_instr = '0; b_req_addr = '0; b_req_wdata = '0;
    b_req_wstrb = '0; b_mrdata = '0; b_mready = 1'b0;
    c_rst = 1'b0; c_req_valid = '0; c_req_instr = '0; c_req_addr = '0; c_req_wdata = '0;
    c_req_wstrb = '0; c_mrdata = '0; c_mready = 1'b0;

`ifdef ARBITER_ROUND_ROBIN_EN
    b_exp_addr[0] = 32'h10; b_exp_addr[1] = 32'h20; b_exp_addr[2] = 32'h30; b_exp_addr[3] = 32'h40;
    b_exp_resp[0] = 3'b000; b_exp_resp[1] = 3'b001; b_exp_resp[2] = 3'b010;
    b_exp_resp[3] = 3'b100; b_exp_resp[4] = 3'b001;
`else
    b_exp_addr[0] = 32'h10; b_exp_addr[1] = 32'h20; b_exp_addr[2] = 32'h40; b_exp_addr[3] = 32'h30;
    b_exp_resp[0] = 3'b000; b_exp_resp[1] = 3'b001; b_exp_resp[2] = 3'b010;
    b_exp_resp[3] = 3'b001; b_exp_resp[4] = 3'b100;
`endif

    repeat (2) tick();
    check("rst_a_valid", a_mv, 1'b0);
    check("rst_a_instr", a_mi, 1'b0);
    check("rst_a_addr", a_ma, 32'h0);
    check("rst_a_wdata", a_mw, 32'h0);
    check("rst_a_wstrb", a_ms, 4'h0);
    check("rst_a_resp", a_resp_ready, 2'b00);
    check("rst_a_rdata", a_resp_rdata, 32'h0);
    check("rst_b_valid", b_mv, 1'b0);
    check("rst_c_valid", c_mv, 1'b0);
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick();

    // Read on channel 0
    a_req_valid = 2'b01; a_req_addr[31:0] = 32'h100;
    tick();
    a_req_valid = 2'b00;
    check("rd_valid", a_mv, 1'b1);
    check("rd_addr", a_ma, 32'h100);
    check("rd_wstrb", a_ms, 4'h0);
    check("rd_instr", a_mi, 1'b0);
    check("rd_resp_early", a_resp_ready, 2'b00);
    a_mrdata = 32'hDEADBEEF; a_mready = 1'b1;
    tick();
    a_mready = 1'b0;
    check("rd_resp", a_resp_ready, 2'b01);
    check("rd_rdata", a_resp_rdata, 32'hDEADBEEF);
    check("rd_idle", a_mv, 1'b0);
    tick();
    check("rd_resp_pulse", a_resp_ready, 2'b00);
    check("rd_rdata_hold", a_resp_rdata, 32'hDEADBEEF);

    // Write on channel 1
    a_req_valid = 2'b10; a_req_addr[63:32] = 32'h200; a_req_wdata[63:32] = 32'h12345678;
    a_req_wstrb[7:4] = 4'hF; a_req_instr = 2'b00;
    tick();
    a_req_valid = 2'b00;
    check("wr_valid", a_mv, 1'b1);
    check("wr_addr", a_ma, 32'h200);
    check("wr_wdata", a_mw, 32'h12345678);
    check("wr_wstrb", a_ms, 4'hF);
    check("wr_instr", a_mi, 1'b0);
    a_mready = 1'b1; a_mrdata = 32'h0BAD0BAD;
    tick();
    a_mready = 1'b0;
    check("wr_resp", a_resp_ready, 2'b10);
    check("wr_idle", a_mv, 1'b0);
    tick();
    check("wr_resp_pulse", a_resp_ready, 2'b00);

    // Stall: ch0 instr fetch held 5 cycles while ch1 pulses and is buffered
    a_req_valid = 2'b01; a_req_instr = 2'b01; a_req_addr[31:0] = 32'h300; a_req_wstrb = '0;
    a_req_wdata = '0;
    tick();
    a_req_valid = 2'b10; a_req_instr = 2'b00; a_req_addr[63:32] = 32'h400;
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", a_mv, 1'b1);
      check("stall_addr", a_ma, 32'h300);
      check("stall_instr", a_mi, 1'b1);
      check("stall_resp", a_resp_ready, 2'b00);
      tick();
      a_req_valid = 2'b00;
    end
    a_mready = 1'b1; a_mrdata = 32'hCAFE0001;
    tick();
    check("stall_resp0", a_resp_ready, 2'b01);
    check("stall_rdata0", a_resp_rdata, 32'hCAFE0001);
    check("stall_next_valid", a_mv, 1'b1);
    check("stall_next_addr", a_ma, 32'h400);
    check("stall_next_instr", a_mi, 1'b0);
    a_mrdata = 32'hCAFE0002;
    tick();
    a_mready = 1'b0;
    check("stall_resp1", a_resp_ready, 2'b10);
    check("stall_rdata1", a_resp_rdata, 32'hCAFE0002);
    check("stall_idle", a_mv, 1'b0);

    // Reset while busy with ch1 pending
    a_req_valid = 2'b01; a_req_addr[31:0] = 32'h500;
    tick();
    a_req_valid = 2'b10; a_req_addr[63:32] = 32'h600;
    tick();
    a_req_valid = 2'b00;
    check("pre_rst_valid", a_mv, 1'b1);
    check("pre_rst_addr", a_ma, 32'h500);
    #2;
    a_rst = 1'b0;
    #1;
    check("async_rst_valid", a_mv, 1'b0);
    check("async_rst_addr", a_ma, 32'h0);
    check("async_rst_rdata", a_resp_rdata, 32'h0);
    check("async_rst_resp", a_resp_ready, 2'b00);
    #2;
    a_rst = 1'b1; a_mready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_valid", a_mv, 1'b0);
      check("post_rst_resp", a_resp_ready, 2'b00);
    end
    a_mready = 1'b0;

    // Three channels, zero-wait memory, ch0 re-pulses on its response
    b_mready = 1'b1;
    b_req_valid = 3'b111;
    b_req_addr = {32'h30, 32'h20, 32'h10};
    tick();
    b_req_valid = 3'b000;
    for (int k = 0; k < 4; k++) begin
      check("rr_valid", b_mv, 1'b1);
      check("rr_addr", b_ma, b_exp_addr[k]);
      check("rr_resp", b_resp_ready, b_exp_resp[k]);
      if (k == 1) begin
        b_req_valid = 3'b001; b_req_addr[31:0] = 32'h40;
      end
      tick();
      b_req_valid = 3'b000;
    end
    check("rr_last_resp", b_resp_ready, b_exp_resp[4]);
    check("rr_idle", b_mv, 1'b0);
    b_mready = 1'b0;

    // Single channel, back-to-back requests pulsed on each response
    c_mready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c_req_valid = 1'b1;
      c_req_addr = 32'h1000 + 32'(k * 4);
      c_mrdata = 32'h5000 + 32'(k);
      tick();
      c_req_valid = 1'b0;
      check("one_valid", c_mv, 1'b1);
      check("one_addr", c_ma, 32'h1000 + 32'(k * 4));
      check("one_resp_low", c_resp_ready, 1'b0);
      tick();
      check("one_resp", c_resp_ready, 1'b1);
      check("one_rdata", c_resp_rdata, 32'h5000 + 32'(k));
      check("one_idle", c_mv, 1'b0);
    end
    tick();
    check("one_resp_end", c_resp_ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
